// File: rtl/load_store_unit_if.sv
// Load/store unit bus bundle: EX request channel, WB response channel and
// the word-only data memory pins. The unit itself uses the slave modport.
interface load_store_unit_if;
    // request channel from EX
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    // data memory pins
    logic        mem_active;
    logic        mem_rw;
    logic [31:0] mem_index;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // response channel to WB
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;

    // unit side
    modport slave (
        input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata, req_rd,
        output req_ready,
        output mem_active, mem_rw, mem_index, mem_wdata,
        input  mem_rdata,
        output resp_valid, resp_data, resp_rd, resp_err,
        input  resp_ready
    );

    // pipeline / memory side
    modport master (
        output req_valid, req_store, req_size, req_signed, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  mem_active, mem_rw, mem_index, mem_wdata,
        output mem_rdata,
        input  resp_valid, resp_data, resp_rd, resp_err,
        output resp_ready
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store controller in front of a word-only data memory.
// One transaction at a time: loads do READ/CAPT, word stores go straight to
// WRITE, sub-word stores read-modify-write (READ/CAPT/WRITE). Every output is
// a flop, so nothing on the memory or WB side depends combinationally on req_*.
module load_store_unit #(
    parameter int MEM_WORDS = 512
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CAPT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t      state;

    // latched request fields needed after the accept cycle
    logic        store_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;

    // registered outputs
    logic        req_ready_r;
    logic        mem_active_r;
    logic        mem_rw_r;
    logic [31:0] mem_index_r;
    logic [31:0] mem_wdata_r;
    logic        resp_valid_r;
    logic [31:0] resp_data_r;
    logic [4:0]  resp_rd_r;
    logic        resp_err_r;

    // Misaligned half/word, reserved size, or a word index past the memory.
    function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = addr[0];
            SZ_WORD: bad = (addr[1:0] != 2'b00);
            SZ_RSVD: bad = 1'b1;
            default: bad = 1'b0;
        endcase
        if ({2'b00, addr[31:2]} >= MEM_LIMIT)
            bad = 1'b1;
        return bad;
    endfunction

    // Pick the addressed little-endian lane and sign/zero extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic        sgn,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane of the old word with the low store bits.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic [31:0] data);
        logic [31:0] r;
        r = word;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0:    r[7:0]   = data[7:0];
                    2'd1:    r[15:8]  = data[7:0];
                    2'd2:    r[23:16] = data[7:0];
                    default: r[31:24] = data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1])
                    r[31:16] = data[15:0];
                else
                    r[15:0] = data[15:0];
            end
            default: r = data;
        endcase
        return r;
    endfunction

    // Transaction sequencer; all outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            store_q      <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= 32'h0;
            rd_q         <= 5'h0;
            req_ready_r  <= 1'b1;
            mem_active_r <= 1'b0;
            mem_rw_r     <= 1'b0;
            mem_index_r  <= 32'h0;
            mem_wdata_r  <= 32'h0;
            resp_valid_r <= 1'b0;
            resp_data_r  <= 32'h0;
            resp_rd_r    <= 5'h0;
            resp_err_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready_r) begin
                        store_q     <= bus.req_store;
                        size_q      <= bus.req_size;
                        signed_q    <= bus.req_signed;
                        off_q       <= bus.req_addr[1:0];
                        wdata_q     <= bus.req_wdata;
                        rd_q        <= bus.req_rd;
                        req_ready_r <= 1'b0;
                        if (access_err(bus.req_size, bus.req_addr)) begin
                            // reject without touching memory
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_data_r  <= 32'h0;
                            resp_rd_r    <= bus.req_rd;
                            state        <= RESP;
                        end else if (bus.req_store && bus.req_size == SZ_WORD) begin
                            mem_active_r <= 1'b1;
                            mem_rw_r     <= 1'b1;
                            mem_index_r  <= {2'b00, bus.req_addr[31:2]};
                            mem_wdata_r  <= bus.req_wdata;
                            state        <= WRITE;
                        end else begin
                            // loads and the read half of a sub-word RMW
                            mem_active_r <= 1'b1;
                            mem_rw_r     <= 1'b0;
                            mem_index_r  <= {2'b00, bus.req_addr[31:2]};
                            state        <= READ;
                        end
                    end
                end

                READ: begin
                    // memory samples the read this edge; data arrives next cycle
                    mem_active_r <= 1'b0;
                    mem_rw_r     <= 1'b0;
                    state        <= CAPT;
                end

                CAPT: begin
                    if (store_q) begin
                        mem_wdata_r  <= store_merge(bus.mem_rdata, size_q, off_q, wdata_q);
                        mem_active_r <= 1'b1;
                        mem_rw_r     <= 1'b1;
                        state        <= WRITE;
                    end else begin
                        resp_data_r  <= load_extract(bus.mem_rdata, size_q, signed_q, off_q);
                        resp_err_r   <= 1'b0;
                        resp_rd_r    <= rd_q;
                        resp_valid_r <= 1'b1;
                        state        <= RESP;
                    end
                end

                WRITE: begin
                    mem_active_r <= 1'b0;
                    mem_rw_r     <= 1'b0;
                    resp_data_r  <= 32'h0;
                    resp_err_r   <= 1'b0;
                    resp_rd_r    <= rd_q;
                    resp_valid_r <= 1'b1;
                    state        <= RESP;
                end

                RESP: begin
                    // hold the response stable until WB takes it
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                        state        <= IDLE;
                    end
                end

                default: begin
                    mem_active_r <= 1'b0;
                    mem_rw_r     <= 1'b0;
                    resp_valid_r <= 1'b0;
                    req_ready_r  <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.mem_active = mem_active_r;
    assign bus.mem_rw     = mem_rw_r;
    assign bus.mem_index  = mem_index_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_data  = resp_data_r;
    assign bus.resp_rd    = resp_rd_r;
    assign bus.resp_err   = resp_err_r;

endmodule
